fifo_memory: RTL and testbench
==============================

// Module: fifo_memory
// PURPOSE
//  Synchronous single-clock FIFO buffer: DEPTH = 2**ADDR_WIDTH entries of DATA_WIDTH bits.
//  Decouples a byte-stream producer from a consumer in the same clock domain.
//  Exposes full/empty flags so both sides self-throttle.
//  Used as the golden RTL FIFO that the shadow model is checked against.
// PARAMETERS
//  DATA_WIDTH  8  width of each stored word
//  ADDR_WIDTH  5  address bits; DEPTH = 2**ADDR_WIDTH (32 by default)
// PORTS
//  clk           in   1           single clock; all state changes on rising edge
//  rstn          in   1           synchronous, active-HIGH reset (rstn=1 resets on next posedge)
//  write_enable  in   1           push request
//  read_enable   in   1           pop request
//  write_data    in   DATA_WIDTH  word to push
//  read_data     out  DATA_WIDTH  registered popped word
//  full          out  1           FIFO holds DEPTH words
//  empty         out  1           FIFO holds 0 words
// BEHAVIOUR
//  - Reset: clk is the only clock. Reset is synchronous and active-high: the port rstn, when 1 at a posedge,
//    resets the block. wr_ptr=0, rd_ptr=0, read_data=0, empty=1, full=0.
//    Storage array contents are not reset.
//  - Pointers are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits index memory; the MSB is the wrap flag.
//  - empty = (wr_ptr == rd_ptr). This flag is combinational from the registered pointers.
//  - full = (addr bits equal) && (MSBs differ). This flag is combinational.
//  - Write accepted iff write_enable && !full:
//    mem[wr_ptr[ADDR_WIDTH-1:0]] <= write_data; wr_ptr <= wr_ptr+1.
//  - Read accepted iff read_enable && !empty:
//    read_data <= mem[rd_ptr[ADDR_WIDTH-1:0]]; rd_ptr <= rd_ptr+1.
//  - Read latency is 1 cycle. read_data is valid after the posedge that accepts the read.
//    read_data holds its value until the next accepted read or reset.
//  - Write to a full FIFO: silently dropped. No pointer or memory change. No error flag.
//  - Read from an empty FIFO: silently ignored. read_data and rd_ptr hold.
//  - Simultaneous read and write:
//    - Each is evaluated independently against the pre-edge flags. Both may occur in one cycle, and occupancy is unchanged.
//    - When full, only the read proceeds. When empty, only the write proceeds. There is no bypass/fall-through.
//  - Wrap-around: pointers roll modulo 2*DEPTH. Ordering is preserved across wrap.
//  - Reset mid-operation: reset wins over any concurrent read/write. Contents are then logically discarded.
//  - Data ordering is strictly first-in first-out. No data corruption at any occupancy.
// STRUCTURE
//  - Shared package fifo_pkg holds:
//    - default DATA_WIDTH/ADDR_WIDTH localparams
//    - DEPTH function/const
//    - typedef ptr_t (ADDR_WIDTH+1 bits)
//  - One natural sub-module: fifo_ram, a simple dual-port register array.
//    - one write port, one registered read port
//    - the top contains pointer/flag logic only
// TESTING
//  1. Reset then idle:
//     rstn=1 for 1 cycle, then 0 -> empty=1, full=0, read_data=8'h00.
//  2. Fill: write 32 words 8'h00..8'h1F on consecutive cycles -> full=1 after the 32nd edge, empty=0.
//     A 33rd write of 8'hAA is dropped.
//  3. Drain: from full, assert read_enable for 32 cycles.
//     -> read_data sequence 00..1F, 1 cycle after each accepted read.
//     -> empty=1 after last; an extra read leaves read_data=8'h1F.
//  4. Wrap:
//     - write 20 words, read 20, write 20 words 8'h40..8'h53, read 20
//     - -> 40..53 in order; flags correct throughout
//  5. Simultaneous read and write:
//     - at occupancy 5, hold both enables for 10 cycles -> occupancy stays 5, FIFO order intact
//     - at full, both asserted -> 1 read, write dropped, full=0 next cycle
//  6. Mid-op reset: with 10 words stored, assert rstn for 1 cycle -> empty=1, read_data=0.
//     A following write/read of 8'h5A returns 8'h5A.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing constants and pointer type for the single-clock FIFO.
// Pointers carry one extra MSB used as a wrap flag to tell full from empty.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    localparam int DEFAULT_DEPTH = fifo_depth(DEFAULT_ADDR_WIDTH);

    typedef logic [DEFAULT_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port register array: one write port, one registered read port.
// Only the read register is reset; storage contents are left untouched.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_word,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_word
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_word;
        end
    end

    // The read register holds its value between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_word <= '0;
        end else if (read_en) begin
            read_word <= mem[read_addr];
        end
    end

endmodule

// File: rtl/fifo_memory.sv
// Single-clock FIFO: pointer and flag logic around a fifo_ram storage array.
// Flags are combinational from the registered pointers; reads have one cycle latency.
module fifo_memory
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                write_accept;
    logic                read_accept;

    // Same address with opposite wrap flags means the writer is a full lap ahead.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    assign write_accept = write_enable && !full;
    assign read_accept  = read_enable && !empty;

    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (write_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rstn),
        .write_en  (write_accept && !rstn),
        .write_addr(wr_ptr[ADDR_WIDTH-1:0]),
        .write_word(write_data),
        .read_en   (read_accept),
        .read_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .read_word (read_data)
    );

endmodule

// File: tb/tb_fifo_memory.sv
// Directed self-checking bench for fifo_memory: reset, fill, drain, wrap,
// simultaneous read/write and mid-operation reset.
module tb_fifo_memory;
    import fifo_pkg::*;

    logic       clk;
    logic       rstn;
    logic       write_enable;
    logic       read_enable;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       full;
    logic       empty;

    int compareCount;
    int failCount;

    fifo_memory dut (
        .clk         (clk),
        .rstn        (rstn),
        .write_enable(write_enable),
        .read_enable (read_enable),
        .write_data  (write_data),
        .read_data   (read_data),
        .full        (full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let a posedge pass, then return 1 ns later.
    task automatic applyStimulus(input logic rst, input logic we, input logic re, input logic [7:0] data);
        rstn         = rst;
        write_enable = we;
        read_enable  = re;
        write_data   = data;
        @(posedge clk);
        #1;
        rstn         = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    initial begin
        ptr_t unusedPtr;
        compareCount = 0;
        failCount    = 0;
        unusedPtr    = '0;
        rstn         = 1'b1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        write_data   = 8'h00;

        $display("[TB] reset then idle");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_full", 32'(full), 32'd0);
        checkOutput("reset_read_data", 32'(read_data), 32'h00);

        $display("[TB] fill");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(i));
            checkOutput("fill_empty", 32'(empty), 32'd0);
            checkOutput("fill_full", 32'(full), (i == 31) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hAA);
        checkOutput("overflow_full", 32'(full), 32'd1);

        $display("[TB] drain");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            checkOutput("drain_data", 32'(read_data), 32'(i));
            checkOutput("drain_full", 32'(full), 32'd0);
            checkOutput("drain_empty", 32'(empty), (i == 31) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("underflow_data", 32'(read_data), 32'h1F);
        checkOutput("underflow_empty", 32'(empty), 32'd1);

        $display("[TB] wrap");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
            checkOutput("wrap1_empty", 32'(empty), 32'd0);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            checkOutput("wrap1_data", 32'(read_data), 32'(8'h20 + i));
            checkOutput("wrap1_empty", 32'(empty), (i == 19) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
            checkOutput("wrap2_full", 32'(full), 32'd0);
            checkOutput("wrap2_empty", 32'(empty), 32'd0);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            checkOutput("wrap2_data", 32'(read_data), 32'(8'h40 + i));
            checkOutput("wrap2_empty", 32'(empty), (i == 19) ? 32'd1 : 32'd0);
        end

        $display("[TB] simultaneous read and write at occupancy 5");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 8'(8'h65 + i));
            checkOutput("rw_data", 32'(read_data), 32'(8'h60 + i));
            checkOutput("rw_empty", 32'(empty), 32'd0);
            checkOutput("rw_full", 32'(full), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            checkOutput("rw_drain_data", 32'(read_data), 32'(8'h6A + i));
            checkOutput("rw_drain_empty", 32'(empty), (i == 4) ? 32'd1 : 32'd0);
        end

        $display("[TB] simultaneous read and write at full");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
        end
        checkOutput("rw_full_before", 32'(full), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hBB);
        checkOutput("rw_full_data", 32'(read_data), 32'h80);
        checkOutput("rw_full_after", 32'(full), 32'd0);
        for (int i = 0; i < 31; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            checkOutput("rw_full_drain", 32'(read_data), 32'(8'h81 + i));
            checkOutput("rw_full_empty", 32'(empty), (i == 30) ? 32'd1 : 32'd0);
        end

        $display("[TB] mid-operation reset");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        end
        checkOutput("pre_reset_empty", 32'(empty), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE);
        checkOutput("midreset_empty", 32'(empty), 32'd1);
        checkOutput("midreset_full", 32'(full), 32'd0);
        checkOutput("midreset_data", 32'(read_data), 32'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A);
        checkOutput("post_reset_empty", 32'(empty), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("post_reset_data", 32'(read_data), 32'h5A);
        checkOutput("post_reset_drained", 32'(empty), 32'd1);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
